// File: rtl/fifo_wr_ptr_full.sv
// rtl/fifo_wr_ptr_full.sv - async FIFO write pointer, Gray export and full/overflow flags
module fifo_wr_ptr_full #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrInc,
  input  logic [ADDR_W:0]   rdPtrGray,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [ADDR_W:0]   wrPtrGray,
  output logic              full,
  output logic              overflow
);

  logic [ADDR_W:0] wr_bin;
  logic [ADDR_W:0] bin_next;
  logic [ADDR_W:0] gray_next;
  logic [ADDR_W:0] rq_sync;
  logic [ADDR_W:0] full_cmp;
  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic            wr_en;

  // Accept a write only when not full; compute next binary and Gray pointers
  always_comb begin
    wr_en     = wrInc & ~full;
    bin_next  = wr_bin + {{ADDR_W{1'b0}}, wr_en};
    gray_next = bin_next ^ (bin_next >> 1);
  end

  assign rq_sync = sync_q[SYNC_STAGES-1];
  assign wrAddr  = wr_bin[ADDR_W-1:0];

  // Full pattern: the read pointer with its two MSBs inverted (Gray of rd + depth)
  generate
    if (ADDR_W == 1) begin : g_cmp_narrow
      assign full_cmp = ~rq_sync;
    end else begin : g_cmp_wide
      assign full_cmp = {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]};
    end
  endgenerate

  // Plain flop chain bringing the read-domain Gray pointer into this clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rdPtrGray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Pointer registers, registered full flag and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin    <= '0;
      wrPtrGray <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wr_bin    <= bin_next;
      wrPtrGray <= gray_next;
      full      <= (gray_next == full_cmp);
      overflow  <= overflow | (wrInc & full);
    end
  end

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// tb/tb_fifo_wr_ptr_full.sv - self-checking bench for fifo_wr_ptr_full (ADDR_W=2, SYNC_STAGES=2)
module tb_fifo_wr_ptr_full;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wrInc = 1'b0;
  logic [2:0] rdPtrGray = 3'b000;
  logic [1:0] wrAddr;
  logic [2:0] wrPtrGray;
  logic       full;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [1:0] addr;
    logic [2:0] gray;
    logic       full;
    logic       ovf;
  } exp_t;

  exp_t q[$];

  // Reference model state: occupancy-based full against the synchronised read pointer
  logic [2:0] m_bin, m_s0, m_s1;
  logic       m_full, m_ovf;

  fifo_wr_ptr_full #(.ADDR_W(2), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .wrInc     (wrInc),
    .rdPtrGray (rdPtrGray),
    .wrAddr    (wrAddr),
    .wrPtrGray (wrPtrGray),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic inc, input logic [2:0] rdg, output exp_t e);
    logic [2:0] bn;
    logic [2:0] occ;
    if (r) begin
      m_bin = '0; m_s0 = '0; m_s1 = '0; m_full = 1'b0; m_ovf = 1'b0;
    end else begin
      bn    = m_bin + {2'b00, (inc & ~m_full)};
      occ   = bn - gray2bin(m_s1);
      m_ovf = m_ovf | (inc & m_full);
      m_full = (occ == 3'd4);
      m_s1  = m_s0;
      m_s0  = rdg;
      m_bin = bn;
    end
    e.addr = m_bin[1:0];
    e.gray = bin2gray(m_bin);
    e.full = m_full;
    e.ovf  = m_ovf;
  endtask

  task automatic step(input logic r, input logic inc, input logic [2:0] rdg);
    exp_t e;
    @(negedge clk);
    rst = r; wrInc = inc; rdPtrGray = rdg;
    model_edge(r, inc, rdg, e);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("model_wrAddr",    {6'd0, wrAddr},    {6'd0, e.addr});
    chk("model_wrPtrGray", {5'd0, wrPtrGray}, {5'd0, e.gray});
    chk("model_full",      {7'd0, full},      {7'd0, e.full});
    chk("model_overflow",  {7'd0, overflow},  {7'd0, e.ovf});
  endtask

  logic [2:0] wrap_seq [9];
  logic [2:0] prev_gray;
  int         w;
  int         rd_bin;
  logic [2:0] occ_now;

  initial begin
    wrap_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
    m_bin = '0; m_s0 = '0; m_s1 = '0; m_full = 1'b0; m_ovf = 1'b0;

    // Reset state, with wrInc high to show it is ignored on a reset edge
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b1, 3'b000);
    chk("reset_wrAddr",    {6'd0, wrAddr},    8'd0);
    chk("reset_wrPtrGray", {5'd0, wrPtrGray}, 8'd0);
    chk("reset_full",      {7'd0, full},      8'd0);
    chk("reset_overflow",  {7'd0, overflow},  8'd0);

    // Fill four slots with the read pointer parked at 0
    for (int i = 0; i < 4; i++) begin
      chk("fill_addr_before", {6'd0, wrAddr}, i[7:0]);
      step(1'b0, 1'b1, 3'b000);
      chk("fill_full", {7'd0, full}, (i == 3) ? 8'd1 : 8'd0);
    end
    chk("fill_wrAddr",    {6'd0, wrAddr},    8'd0);
    chk("fill_wrPtrGray", {5'd0, wrPtrGray}, 8'b110);

    // Write while full is dropped and latches overflow
    step(1'b0, 1'b1, 3'b000);
    chk("ovf_wrPtrGray", {5'd0, wrPtrGray}, 8'b110);
    chk("ovf_wrAddr",    {6'd0, wrAddr},    8'd0);
    chk("ovf_set",       {7'd0, overflow},  8'd1);
    step(1'b0, 1'b0, 3'b000);
    chk("ovf_sticky",    {7'd0, overflow},  8'd1);

    // One read: full releases after three edges
    step(1'b0, 1'b0, 3'b001);
    chk("release_edge1", {7'd0, full}, 8'd1);
    step(1'b0, 1'b0, 3'b001);
    chk("release_edge2", {7'd0, full}, 8'd1);
    step(1'b0, 1'b0, 3'b001);
    chk("release_edge3", {7'd0, full}, 8'd0);
    step(1'b0, 1'b1, 3'b001);
    chk("refill_gray", {5'd0, wrPtrGray}, 8'b111);
    chk("refill_full", {7'd0, full},      8'd1);

    // Reset while full and overflowing, with a write request on the same edge
    chk("pre_reset_full", {7'd0, full},     8'd1);
    chk("pre_reset_ovf",  {7'd0, overflow}, 8'd1);
    step(1'b1, 1'b1, 3'b001);
    chk("midrst_wrAddr",    {6'd0, wrAddr},    8'd0);
    chk("midrst_wrPtrGray", {5'd0, wrPtrGray}, 8'd0);
    chk("midrst_full",      {7'd0, full},      8'd0);
    chk("midrst_overflow",  {7'd0, overflow},  8'd0);

    // Wrap: read pointer trails two behind, nine writes
    step(1'b1, 1'b0, 3'b000);
    w = 0;
    prev_gray = 3'b000;
    for (int i = 0; i < 9; i++) begin
      rd_bin = (w >= 2) ? w - 2 : 0;
      step(1'b0, 1'b1, bin2gray(rd_bin[2:0]));
      w++;
      chk("wrap_gray",   {5'd0, wrPtrGray}, {5'd0, wrap_seq[i]});
      chk("wrap_onebit", 8'($countones(wrPtrGray ^ prev_gray)), 8'd1);
      chk("wrap_full",   {7'd0, full}, 8'd0);
      prev_gray = wrPtrGray;
      rd_bin = (w >= 2) ? w - 2 : 0;
      step(1'b0, 1'b0, bin2gray(rd_bin[2:0]));
      step(1'b0, 1'b0, bin2gray(rd_bin[2:0]));
    end

    // Random writes against a legal, one-step-at-a-time read pointer walk
    step(1'b1, 1'b0, 3'b000);
    rd_bin = 0;
    for (int i = 0; i < 400; i++) begin
      occ_now = m_bin - rd_bin[2:0];
      if (occ_now != 3'd0 && $urandom_range(0, 1) == 1) rd_bin++;
      step(1'b0, 1'($urandom_range(0, 1)), bin2gray(rd_bin[2:0]));
      occ_now = m_bin - rd_bin[2:0];
      if (occ_now == 3'd4) chk("rand_full_when_occ4", {7'd0, full}, 8'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
